lookup_dispatcher: RTL

LOOKUP_DISPATCHER -- requirements
Module: lookup_dispatcher

---
 rtl/lookup_dispatcher.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/lookup_dispatcher.sv
`default_nettype none
// ============================================================================
// Module   : lookup_dispatcher
// Purpose  : Queues packet headers and runs them one at a time through an
//            external lookup engine, with a per-lookup timeout.
// Revision : 1.0 - initial release
// ============================================================================
module lookup_dispatcher #(
   parameter int FIFO_DEPTH     = 4,
   parameter int TIMEOUT_CYCLES = 64,
   parameter int DATA_WIDTH     = 32
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [95:0]           in_dims,
   input  logic [7:0]            in_tag,
   output logic                  lk_start,
   output logic [15:0]           lk_dims_0,
   output logic [15:0]           lk_dims_1,
   output logic [15:0]           lk_dims_2,
   output logic [15:0]           lk_dims_3,
   output logic [15:0]           lk_dims_4,
   output logic [15:0]           lk_dims_5,
   input  logic                  lk_done,
   input  logic [DATA_WIDTH-1:0] lk_result,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [DATA_WIDTH-1:0] out_result,
   output logic [7:0]            out_tag,
   output logic                  out_timeout,
   output logic                  busy,
   output logic [4:0]            fifo_count,
   output logic [15:0]           timeout_cnt
);
   localparam int                  c_PTR_W     = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int                  c_ENTRY_W   = 104;
   localparam int                  c_WAIT_W    = $clog2(TIMEOUT_CYCLES) + 1;
   localparam logic [4:0]          c_DEPTH     = 5'(FIFO_DEPTH);
   localparam logic [c_WAIT_W-1:0] c_WAIT_LAST = c_WAIT_W'(TIMEOUT_CYCLES - 1);

   localparam logic [1:0] c_IDLE  = 2'd0;
   localparam logic [1:0] c_ISSUE = 2'd1;
   localparam logic [1:0] c_WAIT  = 2'd2;
   localparam logic [1:0] c_OUT   = 2'd3;

   logic [1:0]            r_state;
   logic [1:0]            w_next_state;
   logic [c_ENTRY_W-1:0]  r_mem [FIFO_DEPTH];
   logic [c_PTR_W-1:0]    r_wr_ptr;
   logic [c_PTR_W-1:0]    r_rd_ptr;
   logic [4:0]            r_count;
   logic [95:0]           r_hold_dims;
   logic [7:0]            r_hold_tag;
   logic [c_WAIT_W-1:0]   r_wait_cnt;
   logic [DATA_WIDTH-1:0] r_out_result;
   logic [7:0]            r_out_tag;
   logic                  r_out_timeout;
   logic [15:0]           r_timeout_cnt;
   logic                  w_push;
   logic                  w_pop;
   logic                  w_done_hit;
   logic                  w_timeout_hit;

   // in_ready comes only from the registered count, so a full queue never accepts
   assign in_ready      = (r_count < c_DEPTH);
   assign w_push        = in_valid && in_ready;
   assign w_pop         = (r_state == c_IDLE) && (r_count != 5'd0) && !lk_done;
   assign w_done_hit    = (r_state == c_WAIT) && lk_done;
   assign w_timeout_hit = (r_state == c_WAIT) && !lk_done && (r_wait_cnt == c_WAIT_LAST);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= c_IDLE;
      else        r_state <= w_next_state;
   end

   always_comb begin
      w_next_state = r_state;
      case (r_state)
         c_IDLE:  if (w_pop) w_next_state = c_ISSUE;
         c_ISSUE: w_next_state = c_WAIT;
         c_WAIT:  if (w_done_hit || w_timeout_hit) w_next_state = c_OUT;
         c_OUT:   if (out_ready) w_next_state = c_IDLE;
         default: w_next_state = c_IDLE;
      endcase
   end

   always_comb begin
      lk_start  = (r_state == c_ISSUE);
      out_valid = (r_state == c_OUT);
      busy      = (r_state != c_IDLE) || (r_count != 5'd0);
   end

   // Storage array needs no reset: occupancy is tracked by the pointers/count
   always_ff @(posedge clk) begin
      if (w_push) r_mem[r_wr_ptr] <= {in_tag, in_dims};
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= 5'd0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + c_PTR_W'(1);
         if (w_pop)  r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + 5'd1;
            2'b01:   r_count <= r_count - 5'd1;
            default: r_count <= r_count;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_hold_dims   <= '0;
         r_hold_tag    <= '0;
         r_wait_cnt    <= '0;
         r_out_result  <= '0;
         r_out_tag     <= '0;
         r_out_timeout <= 1'b0;
         r_timeout_cnt <= '0;
      end else begin
         if (w_pop) {r_hold_tag, r_hold_dims} <= r_mem[r_rd_ptr];
         if (r_state == c_ISSUE)     r_wait_cnt <= '0;
         else if (r_state == c_WAIT) r_wait_cnt <= r_wait_cnt + c_WAIT_W'(1);
         if (w_done_hit) begin
            r_out_result  <= lk_result;
            r_out_tag     <= r_hold_tag;
            r_out_timeout <= 1'b0;
         end else if (w_timeout_hit) begin
            r_out_result  <= '1;
            r_out_tag     <= r_hold_tag;
            r_out_timeout <= 1'b1;
            if (r_timeout_cnt != 16'hFFFF) r_timeout_cnt <= r_timeout_cnt + 16'd1;
         end
      end
   end

   assign lk_dims_0   = r_hold_dims[15:0];
   assign lk_dims_1   = r_hold_dims[31:16];
   assign lk_dims_2   = r_hold_dims[47:32];
   assign lk_dims_3   = r_hold_dims[63:48];
   assign lk_dims_4   = r_hold_dims[79:64];
   assign lk_dims_5   = r_hold_dims[95:80];
   assign out_result  = r_out_result;
   assign out_tag     = r_out_tag;
   assign out_timeout = r_out_timeout;
   assign fifo_count  = r_count;
   assign timeout_cnt = r_timeout_cnt;

endmodule
`default_nettype wire
